// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sram_ctrl_pkg : states, default timing and counter sizing helper      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_PULSE  = 3'd2,
    ST_HOLD   = 3'd3,
    ST_VSETUP = 3'd4,
    ST_VPULSE = 3'd5,
    ST_VHOLD  = 3'd6
  } state_t;

  localparam int DEF_ADDR_W    = 7;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_PULSE_CYC = 2;
  localparam int DEF_HOLD_CYC  = 1;

  function automatic int cnt_width(input int s, input int p, input int h);
    int m;
    m = (s > p) ? s : p;
    m = (m > h) ? m : h;
    return $clog2(m) + 1;
  endfunction

  localparam int CNT_W = cnt_width(DEF_SETUP_CYC, DEF_PULSE_CYC, DEF_HOLD_CYC);

endpackage
`default_nettype wire

// File: rtl/sram_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sram_ctrl_if : request/response bus between arbiter and sram_ctrl     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface sram_ctrl_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/sram_ctrl_timer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sram_ctrl_timer : loadable down-counter, o_done while count is zero   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module sram_ctrl_timer #(
  parameter int W = 2
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         i_load,
  input  wire logic [W-1:0] i_val,
  output logic              o_done
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);
endmodule
`default_nettype wire

// File: rtl/sram_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sram_ctrl : sequences A/CE#/OE#/WR#/DIO enable for async sram128x8$.  |
// | Option SRAM_CTRL_VERIFY_EN: read-back verify after each write.        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  sram_ctrl_if.slave             bus,
  output logic [ADDR_W-1:0]      sram_a,
  output logic [DATA_W-1:0]      sram_dout,
  output logic                   sram_dout_en,
  input  wire logic [DATA_W-1:0] sram_din,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_wr_n
);
  localparam int c_CNT_W = cnt_width(SETUP_CYC + 1, PULSE_CYC, HOLD_CYC);
  localparam logic [c_CNT_W-1:0] c_LD_SETUP = c_CNT_W'(SETUP_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_LD_PULSE = c_CNT_W'(PULSE_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_LD_HOLD  = c_CNT_W'(HOLD_CYC - 1);
`ifdef SRAM_CTRL_VERIFY_EN
  // One extra setup cycle on the verify read gives DIO a turnaround after the write drive.
  localparam logic [c_CNT_W-1:0] c_LD_VSETUP = c_CNT_W'(SETUP_CYC);
`endif

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_a, w_a_nxt;
  logic [DATA_W-1:0]   r_dout, w_dout_nxt;
  logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
  logic                r_we, w_we_nxt;
  logic                r_dout_en, w_dout_en_nxt;
  logic                r_ce_n, w_ce_n_nxt;
  logic                r_oe_n, w_oe_n_nxt;
  logic                r_wr_n, w_wr_n_nxt;
  logic                r_rsp_valid, w_rsp_valid_nxt;
  logic                w_load;
  logic [c_CNT_W-1:0]  w_load_val;
  logic                w_done;
`ifdef SRAM_CTRL_VERIFY_EN
  logic                r_err, w_err_nxt;
`endif

  sram_ctrl_timer #(.W(c_CNT_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_val  (w_load_val),
    .o_done (w_done)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_a_nxt         = r_a;
    w_dout_nxt      = r_dout;
    w_rdata_nxt     = r_rdata;
    w_we_nxt        = r_we;
    w_dout_en_nxt   = r_dout_en;
    w_ce_n_nxt      = r_ce_n;
    w_oe_n_nxt      = r_oe_n;
    w_wr_n_nxt      = r_wr_n;
    w_rsp_valid_nxt = 1'b0;
    w_load          = 1'b0;
    w_load_val      = '0;
`ifdef SRAM_CTRL_VERIFY_EN
    w_err_nxt       = r_err;
`endif
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          w_state_nxt   = ST_SETUP;
          w_load        = 1'b1;
          w_load_val    = c_LD_SETUP;
          w_a_nxt       = bus.req_addr;
          w_dout_nxt    = bus.req_wdata;
          w_we_nxt      = bus.req_we;
          w_ce_n_nxt    = 1'b0;
          w_dout_en_nxt = bus.req_we;
        end
      end
      ST_SETUP: begin
        if (w_done) begin
          w_state_nxt = ST_PULSE;
          w_load      = 1'b1;
          w_load_val  = c_LD_PULSE;
          if (r_we) begin
            w_wr_n_nxt = 1'b0;
          end else begin
            w_oe_n_nxt    = 1'b0;
            w_dout_en_nxt = 1'b0;
          end
        end
      end
      ST_PULSE: begin
        if (w_done) begin
          w_state_nxt = ST_HOLD;
          w_load      = 1'b1;
          w_load_val  = c_LD_HOLD;
          w_wr_n_nxt  = 1'b1;
          w_oe_n_nxt  = 1'b1;
          if (!r_we) begin
            w_rdata_nxt = sram_din;
          end
        end
      end
      ST_HOLD: begin
        if (w_done) begin
`ifdef SRAM_CTRL_VERIFY_EN
          if (r_we) begin
            w_state_nxt   = ST_VSETUP;
            w_load        = 1'b1;
            w_load_val    = c_LD_VSETUP;
            w_dout_en_nxt = 1'b0;
          end else begin
            w_state_nxt     = ST_IDLE;
            w_ce_n_nxt      = 1'b1;
            w_dout_en_nxt   = 1'b0;
            w_rsp_valid_nxt = 1'b1;
            w_err_nxt       = 1'b0;
          end
`else
          w_state_nxt     = ST_IDLE;
          w_ce_n_nxt      = 1'b1;
          w_dout_en_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
`endif
        end
      end
`ifdef SRAM_CTRL_VERIFY_EN
      ST_VSETUP: begin
        if (w_done) begin
          w_state_nxt = ST_VPULSE;
          w_load      = 1'b1;
          w_load_val  = c_LD_PULSE;
          w_oe_n_nxt  = 1'b0;
        end
      end
      ST_VPULSE: begin
        if (w_done) begin
          w_state_nxt = ST_VHOLD;
          w_load      = 1'b1;
          w_load_val  = c_LD_HOLD;
          w_oe_n_nxt  = 1'b1;
          w_err_nxt   = (sram_din != r_dout);
        end
      end
      ST_VHOLD: begin
        if (w_done) begin
          w_state_nxt     = ST_IDLE;
          w_ce_n_nxt      = 1'b1;
          w_rsp_valid_nxt = 1'b1;
        end
      end
`endif
      default: begin
        w_state_nxt   = ST_IDLE;
        w_ce_n_nxt    = 1'b1;
        w_oe_n_nxt    = 1'b1;
        w_wr_n_nxt    = 1'b1;
        w_dout_en_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_dout      <= '0;
      r_rdata     <= '0;
      r_we        <= 1'b0;
      r_dout_en   <= 1'b0;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_wr_n      <= 1'b1;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_a         <= w_a_nxt;
      r_dout      <= w_dout_nxt;
      r_rdata     <= w_rdata_nxt;
      r_we        <= w_we_nxt;
      r_dout_en   <= w_dout_en_nxt;
      r_ce_n      <= w_ce_n_nxt;
      r_oe_n      <= w_oe_n_nxt;
      r_wr_n      <= w_wr_n_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
    end
  end

`ifdef SRAM_CTRL_VERIFY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_err_nxt;
    end
  end
  assign bus.rsp_err = r_err;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.req_ready = (r_state == ST_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rdata;
  assign sram_a        = r_a;
  assign sram_dout     = r_dout;
  assign sram_dout_en  = r_dout_en;
  assign sram_ce_n     = r_ce_n;
  assign sram_oe_n     = r_oe_n;
  assign sram_wr_n     = r_wr_n;
endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------+
// | tb_sram_ctrl : directed + random bench with SRAM model and reference  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_sram_ctrl;
  localparam int c_SETUP = 1;
  localparam int c_PULSE = 2;
  localparam int c_HOLD  = 1;
  localparam int c_LAT   = c_SETUP + c_PULSE + c_HOLD + 1;
`ifdef SRAM_CTRL_VERIFY_EN
  localparam bit c_VER = 1'b1;
`else
  localparam bit c_VER = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] sram_a;
  logic [7:0] sram_dout, sram_din;
  logic       sram_dout_en, sram_ce_n, sram_oe_n, sram_wr_n;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [128];
  logic [7:0] stuck_mask = 8'hFF;
  logic [7:0] ref_mem [128];
  bit         ref_known [128];

  sram_ctrl_if #(.ADDR_W(7), .DATA_W(8)) bus ();

  sram_ctrl #(
    .ADDR_W(7), .DATA_W(8),
    .SETUP_CYC(c_SETUP), .PULSE_CYC(c_PULSE), .HOLD_CYC(c_HOLD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .sram_a       (sram_a),
    .sram_dout    (sram_dout),
    .sram_dout_en (sram_dout_en),
    .sram_din     (sram_din),
    .sram_ce_n    (sram_ce_n),
    .sram_oe_n    (sram_oe_n),
    .sram_wr_n    (sram_wr_n)
  );

  always #5 clk = ~clk;

  // Async SRAM model: write commits on WR# rise; a reset-forced rise loses the write.
  always @(posedge sram_wr_n) begin
    if (!sram_ce_n && sram_dout_en && rst_n) mem[sram_a] <= sram_dout & stuck_mask;
  end
  assign sram_din = (!sram_ce_n && !sram_oe_n) ? mem[sram_a] : 8'hEE;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus-timing monitor
  logic [6:0] prev_a;
  logic [7:0] prev_dout;
  logic       prev_wr_n = 1'b1, prev_oe_n = 1'b1, prev_ce_n = 1'b1, prev_rst = 1'b0;
  int         setup_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (rst_n && prev_rst) begin
      if (!sram_ce_n) begin
        chk("mon_oe_wr_both_low", {31'b0, !sram_oe_n && !sram_wr_n}, 0);
        chk("mon_oe_with_drive", {31'b0, !sram_oe_n && sram_dout_en}, 0);
      end
      if (sram_a != prev_a)
        chk("mon_a_change_outside_idle", {29'b0, prev_ce_n, prev_wr_n, prev_oe_n}, 3'b111);
      if (!sram_wr_n && !prev_wr_n)
        chk("mon_a_dout_stable_wr", {17'b0, sram_a, sram_dout}, {17'b0, prev_a, prev_dout});
      if (!sram_wr_n && prev_wr_n)
        chk("mon_setup", {31'b0, setup_cnt >= c_SETUP}, 1);
      if (sram_wr_n && !prev_wr_n)
        chk("mon_hold", {16'b0, sram_ce_n, sram_a, sram_dout}, {16'b0, 1'b0, prev_a, prev_dout});
    end
    if (!sram_ce_n && sram_wr_n && sram_oe_n && sram_dout_en)
      setup_cnt = (setup_cnt == 0 || sram_a == prev_a) ? setup_cnt + 1 : 1;
    else
      setup_cnt = 0;
    prev_a    = sram_a;
    prev_dout = sram_dout;
    prev_wr_n = sram_wr_n;
    prev_oe_n = sram_oe_n;
    prev_ce_n = sram_ce_n;
    prev_rst  = rst_n;
  end

  task automatic do_req(input bit we, input logic [6:0] a, input logic [7:0] d, input string tag);
    int lat;
    bit got;
    logic [7:0] stored;
    chk({tag, "_ready"}, {31'b0, bus.req_ready}, 1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      bus.req_valid = 1'b0;
      bus.req_addr  = 7'($urandom);
      bus.req_wdata = 8'($urandom);
      bus.req_we    = 1'($urandom);
      if (bus.rsp_valid) got = 1'b1;
    end
    chk({tag, "_latency"}, lat, (c_VER && we) ? 2 * c_LAT : c_LAT);
    if (we) begin
      stored       = d & stuck_mask;
      ref_mem[a]   = stored;
      ref_known[a] = 1'b1;
      chk({tag, "_err"}, {31'b0, bus.rsp_err}, {31'b0, c_VER && (stored != d)});
    end else begin
      chk({tag, "_rd_err"}, {31'b0, bus.rsp_err}, 0);
      if (ref_known[a]) chk({tag, "_rdata"}, {24'b0, bus.rsp_rdata}, {24'b0, ref_mem[a]});
    end
  endtask

  initial begin
    bit         stayed_high;
    bit         saw_pulse;
    logic [6:0] ra;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < 128; i++) begin
      mem[i]       = 8'h00;
      ref_known[i] = 1'b0;
    end

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobes", {29'b0, sram_ce_n, sram_oe_n, sram_wr_n}, 3'b111);
    chk("rst_a_dout", {17'b0, sram_a, sram_dout}, 0);
    chk("rst_dout_en", {31'b0, sram_dout_en}, 0);
    chk("rst_rsp", {22'b0, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 0);
    chk("rst_ready", {31'b0, bus.req_ready}, 1);
    rst_n = 1'b1;

    stayed_high = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (!(sram_ce_n && sram_oe_n && sram_wr_n) || bus.rsp_valid) stayed_high = 1'b0;
    end
    chk("idle_100_strobes_high", {31'b0, stayed_high}, 1);

    // Corner addresses and data
    do_req(1'b1, 7'h7F, 8'h00, "wr7F");
    do_req(1'b1, 7'h7E, 8'hFF, "wr7E");
    do_req(1'b0, 7'h7F, 8'h00, "rd7F");
    chk("rd7F_const", {24'b0, bus.rsp_rdata}, 32'h00);
    do_req(1'b0, 7'h7E, 8'h00, "rd7E");
    chk("rd7E_const", {24'b0, bus.rsp_rdata}, 32'hFF);

    // Back-to-back writes then read-back
    for (int i = 8'h7D; i >= 8'h70; i--) do_req(1'b1, 7'(i), 8'($urandom), "b2b_wr");
    for (int i = 8'h70; i <= 8'h7D; i++) do_req(1'b0, 7'(i), 8'h00, "b2b_rd");

    // Reset asserted in the middle of a write pulse
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 7'h3F;
    bus.req_wdata = 8'hA5;
    saw_pulse = 1'b0;
    for (int i = 0; i < 10 && !saw_pulse; i++) begin
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      if (!sram_wr_n) saw_pulse = 1'b1;
    end
    chk("rstmid_saw_pulse", {31'b0, saw_pulse}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_wr_n", {31'b0, sram_wr_n}, 1);
    chk("rstmid_dout_en", {31'b0, sram_dout_en}, 0);
    ref_known[7'h3F] = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rstmid_ready", {31'b0, bus.req_ready}, 1);
    chk("rstmid_idle_bus", {30'b0, sram_ce_n, bus.rsp_valid}, 2'b10);

    // Verify path, including a stuck-at-0 bit in the array
    do_req(1'b1, 7'h10, 8'h55, "vfy_ok");
    stuck_mask = 8'hFE;
    do_req(1'b1, 7'h11, 8'h01, "vfy_stuck");
    stuck_mask = 8'hFF;
    do_req(1'b0, 7'h11, 8'h00, "vfy_stuck_rd");
    do_req(1'b0, 7'h10, 8'h00, "vfy_ok_rd");

    // Random traffic against the reference memory
    for (int i = 0; i < 60; i++) begin
      ra = 7'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) do_req(1'b1, ra, 8'($urandom), "rnd_wr");
      else                           do_req(1'b0, ra, 8'h00, "rnd_rd");
    end

    @(posedge clk);
    #1;
    chk("rsp_single_pulse", {31'b0, bus.rsp_valid}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
